// File: rtl/flit_injector.sv
// flit_injector: generates packets of 2N-bit flits for the adder datapath.
// Flit data comes from a Johnson-counter pattern register that advances on
// each valid/ready handshake. Packets are separated by GAP idle cycles and
// a run of NUM_PKT packets ends with a one-cycle done pulse.
// Optional feature macro: FLIT_INJ_HEADER_EN prefixes each packet with a
// header flit {PAYLOAD, pkt_idx}; the pattern does not advance on the header.
module flit_injector #(
  parameter int N       = 25,
  parameter int PAYLOAD = 20,
  parameter int GAP     = 7,
  parameter int NUM_PKT = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] input1,
  output logic [N-1:0] input2,
  output logic         busy,
  output logic         done,
  output logic [7:0]   pkt_idx
);

`ifdef FLIT_INJ_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  localparam int         PKT_LEN   = PAYLOAD + HDR;
  localparam logic [8:0] FLIT_LAST = 9'(PKT_LEN - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
  localparam logic [7:0] PKT_LAST  = 8'(NUM_PKT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] pat_q, pat_d;
  logic [2*N-1:0] data_q, data_d;
  logic [8:0]     flit_cnt_q, flit_cnt_d;
  logic [7:0]     gap_cnt_q, gap_cnt_d;
  logic [7:0]     pkt_q, pkt_d;

  logic [2*N-1:0] pat_step;
  logic [2*N-1:0] pat_adv;

`ifdef FLIT_INJ_HEADER_EN
  // Header flit: low half carries the packet index, high half the payload length.
  function automatic logic [2*N-1:0] header_flit(input logic [7:0] idx);
    logic [2*N-1:0] f;
    f          = '0;
    f[N-1:0]   = N'(idx);
    f[2*N-1:N] = N'(PAYLOAD);
    return f;
  endfunction
  logic [2*N-1:0] hdr_next;
`endif

  // Next-state logic: sequencing of packets, pattern advance and output data
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    data_d     = data_q;
    flit_cnt_d = flit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pkt_d      = pkt_q;

    pat_step = {pat_q[2*N-2:0], ~pat_q[2*N-1]};
`ifdef FLIT_INJ_HEADER_EN
    // The header is flit 0 of each packet and leaves the pattern untouched.
    pat_adv  = (flit_cnt_q == 9'd0) ? pat_q : pat_step;
    hdr_next = header_flit(pkt_q + 8'd1);
`else
    pat_adv  = pat_step;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SEND;
          pat_d      = '0;
          flit_cnt_d = '0;
          gap_cnt_d  = '0;
          pkt_d      = '0;
`ifdef FLIT_INJ_HEADER_EN
          data_d     = header_flit(8'd0);
`else
          data_d     = '0;
`endif
        end
      end

      S_SEND: begin
        if (ready) begin
          pat_d = pat_adv;
          if (flit_cnt_q != FLIT_LAST) begin
            flit_cnt_d = flit_cnt_q + 9'd1;
            data_d     = pat_adv;
          end else begin
            flit_cnt_d = '0;
            if (pkt_q == PKT_LAST) begin
              // Last packet: no trailing gap.
              state_d = S_DONE;
            end else if (GAP == 0) begin
              pkt_d = pkt_q + 8'd1;
`ifdef FLIT_INJ_HEADER_EN
              data_d = hdr_next;
`else
              data_d = pat_adv;
`endif
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_SEND;
          pkt_d   = pkt_q + 8'd1;
`ifdef FLIT_INJ_HEADER_EN
          data_d  = hdr_next;
`else
          data_d  = pat_q;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pat_q      <= '0;
      data_q     <= '0;
      flit_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      data_q     <= data_d;
      flit_cnt_q <= flit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pkt_q      <= pkt_d;
    end
  end

  // Outputs decode directly from registered state; data holds between flits
  always_comb begin
    valid   = (state_q == S_SEND);
    busy    = (state_q == S_SEND) || (state_q == S_GAP);
    done    = (state_q == S_DONE);
    input1  = data_q[N-1:0];
    input2  = data_q[2*N-1:N];
    pkt_idx = pkt_q;
  end

endmodule

// File: tb/tb_flit_injector.sv
// Testbench for flit_injector: a default-parameter instance (A) and a small
// instance (B: N=4, PAYLOAD=4, GAP=0, NUM_PKT=5). Expected flits are built
// from an independent model into a scoreboard queue when a run is started
// and popped as the DUT hands flits off.
module tb_flit_injector;

`ifdef FLIT_INJ_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b, ready;
  logic        valid_a, busy_a, done_a;
  logic [24:0] in1_a, in2_a;
  logic [7:0]  pkt_a;
  logic        valid_b, busy_b, done_b;
  logic [3:0]  in1_b, in2_b;
  logic [7:0]  pkt_b;

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;

  typedef struct {
    logic [63:0] data;
    int          pkt;
    int          pos;
  } flit_t;

  flit_t sb[$];

  flit_injector #(.N(25), .PAYLOAD(20), .GAP(7), .NUM_PKT(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .ready(ready),
    .valid(valid_a), .input1(in1_a), .input2(in2_a),
    .busy(busy_a), .done(done_a), .pkt_idx(pkt_a)
  );

  flit_injector #(.N(4), .PAYLOAD(4), .GAP(0), .NUM_PKT(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ready(ready),
    .valid(valid_b), .input1(in1_b), .input2(in2_b),
    .busy(busy_b), .done(done_b), .pkt_idx(pkt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] obs_data;
  logic        obs_valid, obs_busy, obs_done;
  logic [7:0]  obs_pkt;

  always_comb begin
    if (sel == 1) begin
      obs_data  = 64'({in2_b, in1_b});
      obs_valid = valid_b;
      obs_busy  = busy_b;
      obs_done  = done_b;
      obs_pkt   = pkt_b;
    end else begin
      obs_data  = 64'({in2_a, in1_a});
      obs_valid = valid_a;
      obs_busy  = busy_a;
      obs_done  = done_a;
      obs_pkt   = pkt_a;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 1) start_b = v;
    else        start_a = v;
  endtask

  // One run of a selected instance. timing: check cycle-exact valid/busy/done
  // (ready must be 1). stall_at: hold ready low 3 cycles while flit #stall_at
  // is presented. abort_pkt/abort_pos: assert reset while that flit is shown.
  task automatic run(input int s, input int n, input int pay, input int gap, input int npk,
                     input bit timing, input int stall_at, input bit rnd,
                     input int abort_pkt, input int abort_pos);
    logic [63:0] pat, mask, last_data;
    flit_t       e;
    int          pl, per, done_exp, cyc, hs, stall_left, done_cnt, busy_cnt, t;
    bit          seen_done, finished, aborted, expv;

    sel        = s;
    pl         = pay + HDR;
    per        = pl + gap;
    done_exp   = 1 + npk * pl + (npk - 1) * gap;
    mask       = (64'd1 << (2 * n)) - 64'd1;
    pat        = '0;
    last_data  = '0;
    hs         = 0;
    stall_left = 3;
    done_cnt   = 0;
    busy_cnt   = 0;
    seen_done  = 0;
    finished   = 0;
    aborted    = 0;

    sb.delete();
    for (int p = 0; p < npk; p++) begin
      if (HDR == 1) sb.push_back('{(64'(pay) << n) | 64'(p), p, 0});
      for (int i = 0; i < pay; i++) begin
        sb.push_back('{pat, p, i + HDR});
        pat = ((pat << 1) & mask) | {63'd0, ~pat[2*n-1]};
      end
    end

    @(negedge clk);
    set_start(s, 1'b1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    set_start(s, 1'b0);
    cyc = 1;

    while (!finished) begin
      if (stall_at >= 0 && hs == stall_at && stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else begin
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      // A start pulse in the middle of a run must be ignored.
      if (s == 0) start_a = (cyc == 40);

      @(negedge clk);
      if (obs_valid) begin
        if (sb.size() == 0) begin
          chk("extra_flit", 64'(obs_valid), 64'd0);
        end else begin
          e = sb[0];
          if (abort_pkt >= 0 && e.pkt == abort_pkt && e.pos == abort_pos) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_valid", 64'(obs_valid), 64'd0);
            chk("rst_busy", 64'(obs_busy), 64'd0);
            chk("rst_done", 64'(obs_done), 64'd0);
            chk("rst_pkt", 64'(obs_pkt), 64'd0);
            chk("rst_data", obs_data, 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (4) begin
              @(negedge clk);
              chk("post_rst_valid", 64'(obs_valid), 64'd0);
              chk("post_rst_busy", 64'(obs_busy), 64'd0);
            end
            aborted  = 1;
            finished = 1;
          end else begin
            chk("flit_data", obs_data, e.data);
            chk("flit_pkt", 64'(obs_pkt), 64'(e.pkt));
            if (ready) begin
              last_data = e.data;
              void'(sb.pop_front());
              hs++;
            end
          end
        end
      end else if (hs > 0) begin
        chk("hold_data", obs_data, last_data);
      end

      if (!aborted) begin
        if (timing) begin
          t    = cyc - 1;
          expv = (cyc < done_exp) && ((t % per) < pl);
          chk("valid_timing", 64'(obs_valid), 64'(expv));
          chk("done_timing", 64'(obs_done), 64'(cyc == done_exp));
          chk("busy_timing", 64'(obs_busy), 64'(cyc < done_exp));
        end
        if (obs_busy) busy_cnt++;
        if (obs_done) begin
          done_cnt++;
          seen_done = 1;
        end else if (seen_done) begin
          finished = 1;
        end
        if (cyc > 6000) begin
          chk("timeout", 64'd0, 64'd1);
          finished = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end

    if (s == 0) start_a = 1'b0;
    ready = 1'b1;
    if (!aborted) begin
      chk("flits_left", 64'(sb.size()), 64'd0);
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("end_valid", 64'(obs_valid), 64'd0);
      chk("end_busy", 64'(obs_busy), 64'd0);
      if (timing) chk("busy_cycles", 64'(busy_cnt), 64'(done_exp - 1));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ready   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_a", 64'(valid_a), 64'd0);
    chk("reset_busy_a", 64'(busy_a), 64'd0);
    chk("reset_done_a", 64'(done_a), 64'd0);
    chk("reset_pkt_a", 64'(pkt_a), 64'd0);
    chk("reset_data_a", 64'({in2_a, in1_a}), 64'd0);
    chk("reset_valid_b", 64'(valid_b), 64'd0);
    chk("reset_data_b", 64'({in2_b, in1_b}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", 64'(valid_a), 64'd0);

    // Default run with ready always high: exact cycle timing.
    run(0, 25, 20, 7, 10, 1'b1, -1, 1'b0, -1, -1);
    // Backpressure: 3-cycle stall on flit 5, then random ready.
    run(0, 25, 20, 7, 10, 1'b0, 5, 1'b1, -1, -1);
    // Reset during packet 3, flit 10.
    run(0, 25, 20, 7, 10, 1'b1, -1, 1'b0, 3, 10);
    // Fresh start after the abort must restart the pattern from zero.
    run(0, 25, 20, 7, 10, 1'b1, -1, 1'b0, -1, -1);
    // Small instance: contiguous packets and full Johnson period.
    run(1, 4, 4, 0, 5, 1'b1, -1, 1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
